// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared phase encoding and standard raster constant sets
// Provides phase_e, next_phase() and the 1024x768@60 / 800x600@60 timings.
package vga_timing_pkg;
    typedef enum logic [1:0] {PH_SYNC, PH_BACK, PH_ACTIVE, PH_FRONT} phase_e;
    localparam int XGA_H_ACTIVE  = 1024;
    localparam int XGA_H_FP      = 24;
    localparam int XGA_H_SYNC    = 136;
    localparam int XGA_H_BP      = 160;
    localparam int XGA_V_ACTIVE  = 768;
    localparam int XGA_V_FP      = 3;
    localparam int XGA_V_SYNC    = 6;
    localparam int XGA_V_BP      = 29;
    localparam int SVGA_H_ACTIVE = 800;
    localparam int SVGA_H_FP     = 40;
    localparam int SVGA_H_SYNC   = 128;
    localparam int SVGA_H_BP     = 88;
    localparam int SVGA_V_ACTIVE = 600;
    localparam int SVGA_V_FP     = 1;
    localparam int SVGA_V_SYNC   = 4;
    localparam int SVGA_V_BP     = 23;
    // FRONT wraps back to SYNC through the 2-bit overflow
    function automatic phase_e next_phase(input phase_e p);
        return phase_e'(p + 2'd1);
    endfunction
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: position counter plus SYNC/BACK/ACTIVE/FRONT phase FSM for one raster axis
// Ports: clk, rstn (async active-low), advance (step one position);
//        cnt (0..TOTAL-1), phase, wrap (advance at TOTAL-1), active_idx (offset inside ACTIVE, else 0).
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int SYNC   = 136,
    parameter int BACK   = 160,
    parameter int ACTIVE = 1024,
    parameter int FRONT  = 24,
    parameter int W      = 11
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         advance,
    output logic [W-1:0] cnt,
    output phase_e       phase,
    output logic         wrap,
    output logic [W-1:0] active_idx
);
    localparam int TOTAL = SYNC + BACK + ACTIVE + FRONT;
    logic [W-1:0] cnt_q, cnt_d, pcnt_q, pcnt_d, plen_m1;
    phase_e       phase_q, phase_d;
    logic         phase_end;
    always_comb begin
        plen_m1   = phase_q == PH_SYNC   ? W'(SYNC - 1) :
                    phase_q == PH_BACK   ? W'(BACK - 1) :
                    phase_q == PH_ACTIVE ? W'(ACTIVE - 1) : W'(FRONT - 1);
        phase_end = pcnt_q == plen_m1;
        wrap      = advance && cnt_q == W'(TOTAL - 1);
        cnt_d     = !advance ? cnt_q : wrap ? '0 : cnt_q + 1'b1;
        pcnt_d    = !advance ? pcnt_q : phase_end ? '0 : pcnt_q + 1'b1;
        phase_d   = advance && phase_end ? next_phase(phase_q) : phase_q;
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q   <= '0;
            pcnt_q  <= '0;
            phase_q <= PH_SYNC;
        end else begin
            cnt_q   <= cnt_d;
            pcnt_q  <= pcnt_d;
            phase_q <= phase_d;
        end
    end
    assign cnt        = cnt_q;
    assign phase      = phase_q;
    assign active_idx = phase_q == PH_ACTIVE ? pcnt_q : '0;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: registered raster timing (syncs, de, x/y, line/frame strobes, vblank)
// Ports: clk, rstn (async active-low), en (stall when low);
//        hs, vs, de, x[10:0], y[9:0], line_start, frame_start, vblank -- all registered, 1-clock latency.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = XGA_H_ACTIVE,
    parameter int   H_FP     = XGA_H_FP,
    parameter int   H_SYNC   = XGA_H_SYNC,
    parameter int   H_BP     = XGA_H_BP,
    parameter int   V_ACTIVE = XGA_V_ACTIVE,
    parameter int   V_FP     = XGA_V_FP,
    parameter int   V_SYNC   = XGA_V_SYNC,
    parameter int   V_BP     = XGA_V_BP,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        en,
    output logic        hs,
    output logic        vs,
    output logic        de,
    output logic [10:0] x,
    output logic [9:0]  y,
    output logic        line_start,
    output logic        frame_start,
    output logic        vblank
);
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    if (H_TOTAL > 2048 || V_TOTAL > 1024 || H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_params
        $fatal(1, "vga_timing_gen: illegal timing parameters");
    end
    logic [10:0] h_cnt, h_idx, x_q, x_d;
    logic [9:0]  v_cnt, v_idx, y_q, y_d;
    phase_e      h_phase, v_phase;
    logic        h_wrap, v_wrap_unused;
    logic        hs_q, hs_d, vs_q, vs_d, de_q, de_d, ls_q, ls_d, fs_q, fs_d, vb_q, vb_d;
    vga_axis_counter #(.SYNC(H_SYNC), .BACK(H_BP), .ACTIVE(H_ACTIVE), .FRONT(H_FP), .W(11)) u_h (
        .clk(clk), .rstn(rstn), .advance(en),
        .cnt(h_cnt), .phase(h_phase), .wrap(h_wrap), .active_idx(h_idx)
    );
    // h_wrap is already qualified by en, so the vertical axis steps once per line
    vga_axis_counter #(.SYNC(V_SYNC), .BACK(V_BP), .ACTIVE(V_ACTIVE), .FRONT(V_FP), .W(10)) u_v (
        .clk(clk), .rstn(rstn), .advance(h_wrap),
        .cnt(v_cnt), .phase(v_phase), .wrap(v_wrap_unused), .active_idx(v_idx)
    );
    // Level outputs hold on stall so the reset values survive an initial stall
    always_comb begin
        hs_d = en ? (h_phase == PH_SYNC ? HS_POL : ~HS_POL) : hs_q;
        vs_d = en ? (v_phase == PH_SYNC ? VS_POL : ~VS_POL) : vs_q;
        de_d = en ? h_phase == PH_ACTIVE && v_phase == PH_ACTIVE : de_q;
        x_d  = en ? h_idx : x_q;
        y_d  = en ? v_idx : y_q;
        vb_d = en ? v_phase != PH_ACTIVE : vb_q;
        ls_d = en && h_cnt == '0;
        fs_d = en && h_cnt == '0 && v_cnt == '0;
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hs_q <= ~HS_POL;
            vs_q <= ~VS_POL;
            de_q <= 1'b0;
            x_q  <= '0;
            y_q  <= '0;
            ls_q <= 1'b0;
            fs_q <= 1'b0;
            vb_q <= 1'b1;
        end else begin
            hs_q <= hs_d;
            vs_q <= vs_d;
            de_q <= de_d;
            x_q  <= x_d;
            y_q  <= y_d;
            ls_q <= ls_d;
            fs_q <= fs_d;
            vb_q <= vb_d;
        end
    end
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign de          = de_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
    assign vblank      = vb_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench on a small raster (H 2/2/4/2, V 1/1/3/1, HS_POL=1, VS_POL=0)
module tb_vga_timing_gen;
    localparam int   HS = 2, HB = 2, HA = 4, HF = 2;
    localparam int   VS = 1, VB = 1, VA = 3, VF = 1;
    localparam int   HT = HS + HB + HA + HF;
    localparam int   VT = VS + VB + VA + VF;
    localparam logic HP = 1'b1, VP = 1'b0;
    typedef struct packed {
        logic        hs, vs, de;
        logic [10:0] x;
        logic [9:0]  y;
        logic        ls, fs, vb;
    } exp_t;
    logic        clk = 1'b0, rstn = 1'b0, en = 1'b0;
    logic        hs, vs, de, line_start, frame_start, vblank;
    logic [10:0] x;
    logic [9:0]  y;
    exp_t        q[$];
    exp_t        prev, rst_v;
    int          vectors = 0, miscompares = 0;
    int          mh = 0, mv = 0, cyc = 0, last_fs = -1;
    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(HP), .VS_POL(VP)
    ) dut (
        .clk(clk), .rstn(rstn), .en(en), .hs(hs), .vs(vs), .de(de), .x(x), .y(y),
        .line_start(line_start), .frame_start(frame_start), .vblank(vblank)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d (h=%0d v=%0d)", tag, obs, exp, mh, mv);
        end
    endtask
    task automatic chk_all(input exp_t e);
        chk("hs", 32'(hs), 32'(e.hs));
        chk("vs", 32'(vs), 32'(e.vs));
        chk("de", 32'(de), 32'(e.de));
        chk("x", 32'(x), 32'(e.x));
        chk("y", 32'(y), 32'(e.y));
        chk("line_start", 32'(line_start), 32'(e.ls));
        chk("frame_start", 32'(frame_start), 32'(e.fs));
        chk("vblank", 32'(vblank), 32'(e.vb));
    endtask
    function automatic exp_t model();
        exp_t r;
        logic ha, va;
        ha   = mh >= HS + HB && mh < HS + HB + HA;
        va   = mv >= VS + VB && mv < VS + VB + VA;
        r.hs = mh < HS ? HP : ~HP;
        r.vs = mv < VS ? VP : ~VP;
        r.de = ha && va;
        r.x  = ha ? 11'(mh - HS - HB) : 11'd0;
        r.y  = va ? 10'(mv - VS - VB) : 10'd0;
        r.ls = mh == 0;
        r.fs = mh == 0 && mv == 0;
        r.vb = !va;
        return r;
    endfunction
    task automatic step(input logic e);
        exp_t n;
        en = e;
        n  = prev;
        n.ls = 1'b0;
        n.fs = 1'b0;
        if (e) n = model();
        q.push_back(n);
        prev = n;
        if (e) begin
            cyc++;
            if (mh == HT - 1) begin
                mh = 0;
                mv = mv == VT - 1 ? 0 : mv + 1;
            end else mh++;
        end
        @(posedge clk);
        #1;
        chk_all(q.pop_front());
        if (frame_start) begin
            if (last_fs >= 0) chk("frame_period", 32'(cyc - last_fs), 32'(HT * VT));
            last_fs = cyc;
        end
    endtask
    initial begin
        rst_v.hs = ~HP; rst_v.vs = ~VP; rst_v.de = 1'b0; rst_v.x = '0; rst_v.y = '0;
        rst_v.ls = 1'b0; rst_v.fs = 1'b0; rst_v.vb = 1'b1;
        prev = rst_v;
        en   = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk_all(rst_v);
        end
        rstn = 1'b1;
        repeat (140) step(1'b1);
        for (int i = 0; i < 2 * HT * VT && !(mv == VS + VB + 1 && mh == HS + HB + 1); i++) step(1'b1);
        repeat (17) step(1'b0);
        repeat (25) step(1'b1);
        for (int i = 0; i < HT && mh != 5; i++) step(1'b1);
        #2 rstn = 1'b0;
        #1 chk_all(rst_v);
        @(posedge clk);
        #1;
        chk_all(rst_v);
        rstn = 1'b1;
        mh = 0;
        mv = 0;
        prev = rst_v;
        last_fs = -1;
        repeat (2) step(1'b0);
        repeat (130) step(1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
